// File: rtl/xnor_compare_pipe.sv
// Two-stage masked XNOR comparator with popcount,
// equality flag and consecutive-match run detector.
module xnor_compare_pipe #(
  parameter  int WIDTH   = 8,
  parameter  int RUN_LEN = 4,
  localparam int POP_W   = $clog2(WIDTH + 1),
  localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outY,
  output logic [POP_W-1:0] out_pop,
  output logic             out_eq,
  output logic [CNT_W-1:0] run_count,
  output logic             run_hit
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    HIT      = 2'd2
  } run_state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_y;
  logic             s1_eq;
  logic             s2_valid;
  logic             s2_load;
  logic             in_fire;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  run_state_t       state;
  run_state_t       state_n;

  function automatic logic [POP_W-1:0] popcnt(
    input logic [WIDTH-1:0] v
  );
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = s + POP_W'(v[i]);
    end
    return s;
  endfunction

  // Handshake and stage-advance qualifiers
  always_comb begin
    in_ready  = !clear && (!s1_valid || !s2_valid || out_ready);
    in_fire   = in_valid && in_ready;
    s2_load   = s1_valid && (!s2_valid || out_ready);
    s1_eq     = &s1_y;
    out_valid = s2_valid;
    cnt_inc   = cnt + CNT_ONE;
  end

  // Stage 1: capture the masked XNOR vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_y     <= ~(inA ^ inB) | ~mask;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: result vector, popcount and equality flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      outY     <= '0;
      out_pop  <= '0;
      out_eq   <= 1'b0;
    end else if (clear) begin
      s2_valid <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        outY     <= s1_y;
        out_pop  <= popcnt(s1_y);
        out_eq   <= s1_eq;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Run detector state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Run detector next state, advancing only on S2 load
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (s2_load) begin
      unique case (state)
        IDLE: begin
          if (s1_eq) begin
            cnt_n   = CNT_ONE;
            state_n = (RUN_MAX == CNT_ONE) ? HIT : COUNTING;
          end
        end
        COUNTING: begin
          if (s1_eq) begin
            cnt_n   = cnt_inc;
            state_n = (cnt_inc == RUN_MAX) ? HIT : COUNTING;
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        HIT: begin
          if (!s1_eq) begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  // Run detector outputs
  always_comb begin
    run_count = cnt;
    run_hit   = (state == HIT);
  end

endmodule

// File: tb/tb_xnor_compare_pipe.sv
// Directed and scoreboard checks for xnor_compare_pipe
// (WIDTH=8, RUN_LEN=4).
module tb_xnor_compare_pipe;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inA;
  logic [7:0] inB;
  logic [7:0] mask;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] outY;
  logic [3:0] out_pop;
  logic       out_eq;
  logic [2:0] run_count;
  logic       run_hit;

  int checks = 0;
  int errors = 0;

  xnor_compare_pipe #(.WIDTH(8), .RUN_LEN(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .outY(outY), .out_pop(out_pop), .out_eq(out_eq),
    .run_count(run_count), .run_hit(run_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] y;
    logic [3:0] pop;
    logic       eq;
    logic [2:0] rc;
    logic       hit;
  } vec_t;

  vec_t tbl[13];

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qm[$];
  logic [7:0] gy[$];
  logic [3:0] gp[$];
  logic       ge[$];
  logic [2:0] gc[$];
  logic       gh[$];
  logic       tr_rdy[64];
  logic       tr_v[64];
  logic [7:0] tr_y[64];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    clear    = 1'b1;
    in_valid = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: stalled 5 cycles
  task automatic stream(input int mode, input int maxc);
    int idx = 0;
    int c   = 0;
    int n   = qa.size();
    gy.delete(); gp.delete(); ge.delete();
    gc.delete(); gh.delete();
    while (gy.size() < n && c < maxc) begin
      in_valid = (idx < n);
      if (idx < n) begin
        inA  = qa[idx];
        inB  = qb[idx];
        mask = qm[idx];
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (c >= 5);
      endcase
      #1;
      if (c < 64) begin
        tr_rdy[c] = in_ready;
        tr_v[c]   = out_valid;
        tr_y[c]   = outY;
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        gy.push_back(outY);
        gp.push_back(out_pop);
        ge.push_back(out_eq);
        gc.push_back(run_count);
        gh.push_back(run_hit);
      end
      tick();
      c++;
    end
    in_valid = 1'b0;
    chk("stream_done", gy.size(), n);
  endtask

  task automatic load1(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] m);
    qa.push_back(a);
    qb.push_back(b);
    qm.push_back(m);
  endtask

  task automatic qclear();
    qa.delete();
    qb.delete();
    qm.delete();
  endtask

  initial begin
    logic [7:0] ea[$];
    logic [3:0] ep[$];
    logic       eq_q[$];
    logic [2:0] ec[$];
    logic       eh[$];
    int         mism;
    int         mc;

    tbl[0]  = '{8'h3C, 8'h3C, 8'hFF, 8'hFF, 4'd8, 1'b1, 3'd1, 1'b0};
    tbl[1]  = '{8'hF0, 8'h0F, 8'hFF, 8'h00, 4'd0, 1'b0, 3'd0, 1'b0};
    tbl[2]  = '{8'hA5, 8'hA4, 8'hFE, 8'hFF, 4'd8, 1'b1, 3'd1, 1'b0};
    tbl[3]  = '{8'h00, 8'hFF, 8'h00, 8'hFF, 4'd8, 1'b1, 3'd2, 1'b0};
    tbl[4]  = '{8'h12, 8'h34, 8'hFF, 8'hD9, 4'd5, 1'b0, 3'd0, 1'b0};
    tbl[5]  = '{8'h55, 8'h55, 8'hFF, 8'hFF, 4'd8, 1'b1, 3'd1, 1'b0};
    tbl[6]  = '{8'h5A, 8'h5A, 8'hFF, 8'hFF, 4'd8, 1'b1, 3'd2, 1'b0};
    tbl[7]  = '{8'hC3, 8'hC3, 8'hFF, 8'hFF, 4'd8, 1'b1, 3'd3, 1'b0};
    tbl[8]  = '{8'h81, 8'h81, 8'hFF, 8'hFF, 4'd8, 1'b1, 3'd4, 1'b1};
    tbl[9]  = '{8'h7E, 8'h7E, 8'hFF, 8'hFF, 4'd8, 1'b1, 3'd4, 1'b1};
    tbl[10] = '{8'h01, 8'h00, 8'hFF, 8'hFE, 4'd7, 1'b0, 3'd0, 1'b0};
    tbl[11] = '{8'h0F, 8'h00, 8'h0F, 8'hF0, 4'd4, 1'b0, 3'd0, 1'b0};
    tbl[12] = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 4'd4, 1'b0, 3'd0, 1'b0};

    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inA       = '0;
    inB       = '0;
    mask      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outY", outY, 0);
    chk("rst_out_pop", out_pop, 0);
    chk("rst_out_eq", out_eq, 0);
    chk("rst_run_count", run_count, 0);
    chk("rst_run_hit", run_hit, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    // Table: one pair at a time, bubbles between results
    for (int i = 0; i < 13; i++) begin
      qclear();
      load1(tbl[i].a, tbl[i].b, tbl[i].m);
      stream(0, 20);
      if (i == 0) begin
        chk("latency_c1", tr_v[1], 0);
        chk("latency_c2", tr_v[2], 1);
      end
      if (gy.size() == 1) begin
        chk($sformatf("tbl%0d_y", i), gy[0], tbl[i].y);
        chk($sformatf("tbl%0d_pop", i), gp[0], tbl[i].pop);
        chk($sformatf("tbl%0d_eq", i), ge[0], tbl[i].eq);
        chk($sformatf("tbl%0d_rc", i), gc[0], tbl[i].rc);
        chk($sformatf("tbl%0d_hit", i), gh[0], tbl[i].hit);
      end
    end

    // Back-to-back run: five equal then one unequal
    flush();
    qclear();
    for (int i = 0; i < 5; i++) load1(8'h96, 8'h96, 8'hFF);
    load1(8'h96, 8'h97, 8'hFF);
    stream(0, 40);
    if (gc.size() == 6) begin
      chk("run_rc0", gc[0], 1); chk("run_hit0", gh[0], 0);
      chk("run_rc1", gc[1], 2); chk("run_hit1", gh[1], 0);
      chk("run_rc2", gc[2], 3); chk("run_hit2", gh[2], 0);
      chk("run_rc3", gc[3], 4); chk("run_hit3", gh[3], 1);
      chk("run_rc4", gc[4], 4); chk("run_hit4", gh[4], 1);
      chk("run_rc5", gc[5], 0); chk("run_hit5", gh[5], 0);
    end

    // Backpressure: stalled for five cycles, then released
    flush();
    qclear();
    for (int i = 0; i < 4; i++) load1(8'h10 + 8'(i), 8'h10, 8'hFF);
    stream(2, 40);
    chk("bp_rdy0", tr_rdy[0], 1);
    chk("bp_rdy1", tr_rdy[1], 1);
    chk("bp_rdy2", tr_rdy[2], 0);
    chk("bp_rdy3", tr_rdy[3], 0);
    chk("bp_rdy4", tr_rdy[4], 0);
    chk("bp_v2", tr_v[2], 1);
    chk("bp_y3", tr_y[3], 8'hFF);
    chk("bp_y4", tr_y[4], 8'hFF);
    if (gy.size() == 4) begin
      chk("bp_ord0", gy[0], 8'hFF);
      chk("bp_ord1", gy[1], 8'hFE);
      chk("bp_ord2", gy[2], 8'hFD);
      chk("bp_ord3", gy[3], 8'hFC);
    end

    // clear with both stages full and run_count=3
    flush();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inA       = 8'h66;
    inB       = 8'h66;
    mask      = 8'hFF;
    repeat (4) tick();
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_pre_rc", run_count, 3);
    clear     = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("clr_in_ready", in_ready, 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_rc", run_count, 0);
    tick();
    chk("clr_no_ghost", out_valid, 0);
    qclear();
    load1(8'h66, 8'h66, 8'hFF);
    stream(0, 20);
    if (gc.size() == 1) chk("clr_next_rc", gc[0], 1);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) tick();
    chk("ar_pre_valid", out_valid, 1);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_outY", outY, 0);
    chk("ar_rc", run_count, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_in_ready", in_ready, 1);
    tick();
    chk("ar_after_valid", out_valid, 0);

    // Random stream with random ready against a reference model
    qclear();
    mc = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] m;
      logic [7:0] y;
      logic [3:0] p;
      a = 8'($urandom);
      b = ($urandom_range(0, 2) == 0) ? 8'($urandom) : a;
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      load1(a, b, m);
      y = ~(a ^ b) | ~m;
      p = 4'd0;
      for (int k = 0; k < 8; k++) p = p + 4'(y[k]);
      if (y == 8'hFF) mc = (mc == 4) ? 4 : mc + 1;
      else mc = 0;
      ea.push_back(y);
      ep.push_back(p);
      eq_q.push_back(y == 8'hFF);
      ec.push_back(3'(mc));
      eh.push_back(mc == 4);
    end
    stream(1, 10000);
    mism = 0;
    for (int i = 0; i < gy.size(); i++) begin
      if (gy[i] !== ea[i] || gp[i] !== ep[i] ||
          ge[i] !== eq_q[i] || gc[i] !== ec[i] ||
          gh[i] !== eh[i]) begin
        if (mism == 0)
          $display("first random diff at %0d y=%0h/%0h rc=%0d/%0d",
                   i, gy[i], ea[i], gc[i], ec[i]);
        mism++;
      end
    end
    chk("random_mismatches", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
